// File: rtl/delay_pkg.sv
// Shared defaults, output-select encoding and channel-slice helpers for the
// multichannel delay line.
package delay_pkg;

    localparam int unsigned DW_DEF  = 16;
    localparam int unsigned AW_DEF  = 8;
    localparam int unsigned NCH_DEF = 2;

    // Source of each channel's output word, decided on the strobe cycle
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_BYP  = 2'd1,
        SEL_RAM  = 2'd2
    } out_sel_e;

    function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port sample buffer: synchronous write, synchronous read with
// read enable so the output word holds between strobes. No reset.
module delay_ram #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/delay_mc.sv
// Multichannel sample delay line: shared write pointer and fill counter,
// per-channel clamped delay with bypass and zero fill until history exists.
module delay_mc
    import delay_pkg::*;
#(
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned NCH       = NCH_DEF,
    parameter int unsigned MAX_DELAY = (1 << AW) - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_in,
    input  logic [NCH*DW-1:0] sig_in,
    input  logic [NCH*AW-1:0] delay,
    output logic              ce_out,
    output logic [NCH*DW-1:0] sig_out,
    output logic [NCH-1:0]    fill_ok
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] fill_cnt_q, fill_cnt_d;
    logic          ce_out_q;

    // Shared pointer advance and saturating count of strobes since reset
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        if (ce_in) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (fill_cnt_q != '1) begin
                fill_cnt_d = fill_cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            ce_out_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            ce_out_q   <= ce_in;
        end
    end

    assign ce_out = ce_out_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam int unsigned DLO = ch_lo(c, DW);
        localparam int unsigned ALO = ch_lo(c, AW);

        logic [AW-1:0] dly_raw;
        logic [AW-1:0] d_eff;
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] ram_rdata;
        logic [DW-1:0] byp_q, byp_d;
        out_sel_e      sel_q, sel_d;

        assign dly_raw = delay[ALO +: AW];
        assign d_eff   = (32'(dly_raw) > MAX_DELAY) ? AW'(MAX_DELAY) : dly_raw;
        assign rd_addr = wr_ptr_q - d_eff;

        delay_ram #(
            .DW (DW),
            .AW (AW)
        ) u_ram (
            .clk     (clk),
            .we_i    (ce_in),
            .waddr_i (wr_ptr_q),
            .wdata_i (sig_in[DLO +: DW]),
            .re_i    (ce_in),
            .raddr_i (rd_addr),
            .rdata_o (ram_rdata)
        );

        // Choose bypass, buffer read or zero fill; held until the next strobe
        always_comb begin
            sel_d = sel_q;
            byp_d = byp_q;
            if (ce_in) begin
                if (d_eff == '0) begin
                    sel_d = SEL_BYP;
                    byp_d = sig_in[DLO +: DW];
                end else if (d_eff > fill_cnt_q) begin
                    sel_d = SEL_ZERO;
                end else begin
                    sel_d = SEL_RAM;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sel_q <= SEL_ZERO;
                byp_q <= '0;
            end else begin
                sel_q <= sel_d;
                byp_q <= byp_d;
            end
        end

        assign sig_out[DLO +: DW] = (sel_q == SEL_RAM) ? ram_rdata :
                                    (sel_q == SEL_BYP) ? byp_q : '0;
        assign fill_ok[c] = (sel_q != SEL_ZERO);
    end

endmodule

// File: tb/tb_delay_mc.sv
// Self-checking bench for delay_mc: directed scenarios plus random traffic,
// compared against a history-list model of the delay line.
module tb_delay_mc;

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned NCH  = 2;
    localparam int unsigned MAXD = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              ce_in;
    logic [NCH*DW-1:0] sig_in;
    logic [NCH*AW-1:0] delay;
    logic              ce_out;
    logic [NCH*DW-1:0] sig_out;
    logic [NCH-1:0]    fill_ok;

    always #5 clk = ~clk;

    delay_mc #(
        .DW        (DW),
        .AW        (AW),
        .NCH       (NCH),
        .MAX_DELAY (MAXD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ce_in   (ce_in),
        .sig_in  (sig_in),
        .delay   (delay),
        .ce_out  (ce_out),
        .sig_out (sig_out),
        .fill_ok (fill_ok)
    );

    // Model: every word strobed in since the last reset, oldest first
    logic [NCH*DW-1:0] hist [$];
    logic [NCH*DW-1:0] exp_sig;
    logic [NCH-1:0]    exp_ok;
    logic              exp_ce;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_chk++;
        assert (obs === req) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    task automatic step(input logic rst, input logic ce,
                        input logic [NCH*DW-1:0] s, input logic [NCH*AW-1:0] d);
        logic [NCH*DW-1:0] word;
        int unsigned n, dd;
        @(negedge clk);
        reset  = rst;
        ce_in  = ce;
        sig_in = s;
        delay  = d;
        if (rst) begin
            hist.delete();
            exp_ce  = 1'b0;
            exp_sig = '0;
            exp_ok  = '0;
        end else begin
            exp_ce = ce;
            if (ce) begin
                n = hist.size();
                for (int c = 0; c < NCH; c++) begin
                    dd = d[c*AW +: AW];
                    if (dd > MAXD) dd = MAXD;
                    if (dd == 0) begin
                        exp_sig[c*DW +: DW] = s[c*DW +: DW];
                        exp_ok[c] = 1'b1;
                    end else if (dd > n) begin
                        exp_sig[c*DW +: DW] = '0;
                        exp_ok[c] = 1'b0;
                    end else begin
                        word = hist[n - dd];
                        exp_sig[c*DW +: DW] = word[c*DW +: DW];
                        exp_ok[c] = 1'b1;
                    end
                end
                hist.push_back(s);
            end
        end
        @(posedge clk);
        #1;
        check("ce_out",   64'(ce_out),          64'(exp_ce));
        check("sig_out0", 64'(sig_out[0 +: DW]), 64'(exp_sig[0 +: DW]));
        check("sig_out1", 64'(sig_out[DW +: DW]), 64'(exp_sig[DW +: DW]));
        check("fill_ok",  64'(fill_ok),         64'(exp_ok));
    endtask

    function automatic logic [NCH*DW-1:0] pack2(input int unsigned s1, input int unsigned s0);
        return {DW'(s1), DW'(s0)};
    endfunction

    function automatic logic [NCH*AW-1:0] dly2(input int unsigned d1, input int unsigned d0);
        return {AW'(d1), AW'(d0)};
    endfunction

    initial begin
        reset  = 1'b1;
        ce_in  = 1'b0;
        sig_in = '0;
        delay  = '0;
        exp_ce = 1'b0;
        exp_sig = '0;
        exp_ok  = '0;

        // Reset state
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b1, pack2(16'h1111, 16'h2222), dly2(0, 0));

        // Fill on ch0 (delay 3, ramp) and bypass on ch1 (delay 0, constant)
        for (int k = 1; k <= 10; k++) step(1'b0, 1'b1, pack2(16'hABCD, k), dly2(0, 3));

        // Maximum delay across two pointer wraps
        step(1'b1, 1'b0, '0, '0);
        for (int k = 1; k <= 40; k++) step(1'b0, 1'b1, pack2(k + 100, k), dly2(MAXD, MAXD));

        // Live delay change 2 -> 5 -> 1
        step(1'b1, 1'b0, '0, '0);
        for (int k = 1; k <= 20; k++) step(1'b0, 1'b1, pack2(k * 3, k), dly2(7, 2));
        for (int k = 21; k <= 24; k++) step(1'b0, 1'b1, pack2(k * 3, k), dly2(7, 5));
        for (int k = 25; k <= 28; k++) step(1'b0, 1'b1, pack2(k * 3, k), dly2(0, 1));

        // Gated strobe every third cycle
        step(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 36; k++) step(1'b0, (k % 3) == 0, pack2(k + 500, k + 1), dly2(2, 2));

        // Reset mid-stream coincident with a strobe
        step(1'b1, 1'b0, '0, '0);
        for (int k = 1; k <= 9; k++) step(1'b0, 1'b1, pack2(k + 900, k + 50), dly2(4, 4));
        step(1'b1, 1'b1, pack2(910, 60), dly2(4, 4));
        for (int k = 11; k <= 18; k++) step(1'b0, 1'b1, pack2(k + 900, k + 50), dly2(4, 4));

        // Random traffic with occasional resets
        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0,
                 pack2($urandom, $urandom),
                 dly2($urandom_range(0, 15), $urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/delay_mc.md
DELAY_MC -- requirements
Module: delay_mc

Interface
REQ-001 SHALL have parameter DW, default 16: sample word length per channel.
REQ-002 SHALL have parameter AW, default 8: buffer address width; buffer depth 2**AW per channel.
REQ-003 SHALL have parameter NCH, default 2: number of parallel channels.
REQ-004 SHALL have parameter MAX_DELAY, default 2**AW-1: largest honoured delay; legal range 1..2**AW-1.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port ce_in  input  1  sample strobe; all channels advance together.
REQ-008 SHALL have port sig_in  input  NCH*DW  packed samples; channel c at bits [c*DW +: DW].
REQ-009 SHALL have port delay  input  NCH*AW  packed per-channel delay in samples, unsigned; channel c at [c*AW +: AW].
REQ-010 SHALL have port ce_out  output  1  strobe aligned with sig_out.
REQ-011 SHALL have port sig_out  output  NCH*DW  packed delayed samples, same packing as sig_in.
REQ-012 SHALL have port fill_ok  output  NCH  per-channel flag: current sig_out word is true history, not zero fill.

Function
REQ-013 SHALL register ce_out <= ce_in every clk cycle; one-cycle latency from ce_in to ce_out.
REQ-014 SHALL share one AW-bit write pointer wr_ptr across channels; on ce_in, write sig_in of every channel at wr_ptr, then wr_ptr <= wr_ptr+1 mod 2**AW.
REQ-015 SHALL compute effective delay per channel: D = min(delay_c, MAX_DELAY), sampled in the same cycle as ce_in; no other latching.
REQ-016 SHALL, on ce_in with D=0, load sig_out channel with the current sig_in channel (bypass), fill_ok=1.
REQ-017 SHALL, on ce_in with D>=1, read address (wr_ptr - D) mod 2**AW; sig_out channel = sample written D strobes earlier.
REQ-018 SHALL keep a saturating fill counter fill_cnt (AW bits, saturates at 2**AW-1) counting ce_in events since reset.
REQ-019 SHALL, when D > fill_cnt on ce_in, drive that channel's sig_out to 0 and fill_ok to 0; otherwise fill_ok=1.
REQ-020 SHALL hold sig_out and fill_ok unchanged on cycles without ce_in.
REQ-021 SHALL apply a delay change on the very next ce_in with no glitch: output is always either exact history or zero, never stale or unwritten data.
REQ-022 SHALL treat a read address never equal to wr_ptr when D>=1 (no read-during-write hazard); wrap-around of wr_ptr requires no special case.
REQ-023 SHALL treat channels independently for delay, clamping and fill_ok; they share only wr_ptr, fill_cnt and ce_out.

Reset
REQ-024 SHALL, on reset=1 at a clk edge, set wr_ptr=0, fill_cnt=0, ce_out=0, sig_out=0, fill_ok=0; reset overrides a coincident ce_in.
REQ-025 SHALL NOT clear buffer memory on reset; zero-fill via fill_cnt guarantees pre-reset data never reaches sig_out.
REQ-026 SHALL, on reset mid-stream, restart fill tracking as from power-up at the first subsequent ce_in.

Structure
REQ-027 SHALL place default DW, AW, NCH values and the channel-slice width helpers in shared package delay_pkg.
REQ-028 SHALL instantiate one sub-module delay_ram per channel: simple dual-port, 2**AW x DW, synchronous write, synchronous read, inferable as block RAM.
REQ-029 SHALL keep pointer, fill counter, clamp and zero-fill muxing in delay_mc; delay_ram has no reset.

Verification (DW=16, AW=4, NCH=2, MAX_DELAY=15)
REQ-030 SHALL check fill: reset, then ce_in every cycle with ramp 1,2,3,...; delay ch0=3 -> sig_out ch0 = 0,0,0,1,2,3...; fill_ok 0,0,0,1,1...
REQ-031 SHALL check bypass: delay ch1=0, sig_in ch1=0xABCD -> sig_out ch1=0xABCD one clk later, fill_ok=1 from first strobe.
REQ-032 SHALL check wrap and max: delay=15 for 40 strobes of ramp -> sig_out = input-15 after strobe 15; exact across wr_ptr wrap at 16 and 32.
REQ-033 SHALL check live change: after 20 strobes at delay 2, switch to 5 -> next output = sample 5 back, no other value in between; switch to 1 -> sample 1 back.
REQ-034 SHALL check gated strobe: ce_in every 3rd cycle, delay 2 -> output equals sample two strobes back; sig_out held between strobes; ce_out one clk after each ce_in.
REQ-035 SHALL check reset mid-stream: reset at strobe 10 coincident with ce_in, delay=4 -> outputs 0 with fill_ok=0 for 4 strobes after reset, no pre-reset sample emitted.
